// File: rtl/dmem_responder.sv
// Word-organised RV32 data memory behind a valid/ready request/response pair, with a fixed response latency.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into error responses.
module dmem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 2048,
  parameter int LATENCY   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   mem [MEM_WORDS];

  logic              eff_we;
  logic [2:0]        eff_funct3;
  logic [XLEN-1:0]   eff_addr;
  logic [XLEN-1:0]   eff_wdata;
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic [XLEN-1:0]   old_word;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic              bad_funct3;
  logic              misalign;
  logic              err_c;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   rdata_c;
  logic [XLEN/8-1:0] byte_en;
  logic [XLEN-1:0]   store_pat;
  logic [XLEN-1:0]   merged;
  logic              accept;
  logic              enter_resp;
  logic              mem_we;
  logic              unused_addr_bits;

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign enter_resp  = !rst_i && ((accept && (LATENCY == 1)) || (state == WAIT && cnt == 3'd0));
  assign mem_we      = enter_resp && eff_we && !err_c;

  // With LATENCY=1 the access happens on the accept edge, so the live inputs must be decoded before they are captured.
  assign eff_we     = (state == IDLE) ? req_we_i     : we_q;
  assign eff_funct3 = (state == IDLE) ? req_funct3_i : funct3_q;
  assign eff_addr   = (state == IDLE) ? req_addr_i   : addr_q;
  assign eff_wdata  = (state == IDLE) ? req_wdata_i  : wdata_q;

  assign idx              = eff_addr[AW+1:2];
  assign lane             = eff_addr[1:0];
  assign unused_addr_bits = ^eff_addr[XLEN-1:AW+2];
  assign old_word         = mem[idx];
  assign byte_val         = old_word[{lane, 3'b000} +: 8];
  assign half_val         = old_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    bad_funct3 = 1'b0;
    misalign   = 1'b0;
    load_data  = '0;
    byte_en    = '0;
    store_pat  = eff_wdata;
    if (eff_we) begin
      case (eff_funct3)
        3'b000: begin
          byte_en[lane] = 1'b1;
          store_pat     = {(XLEN/8){eff_wdata[7:0]}};
        end
        3'b001: begin
          byte_en[{lane[1], 1'b0}] = 1'b1;
          byte_en[{lane[1], 1'b1}] = 1'b1;
          store_pat                = {(XLEN/16){eff_wdata[15:0]}};
        end
        3'b010:  byte_en = '1;
        default: bad_funct3 = 1'b1;
      endcase
    end else begin
      case (eff_funct3)
        3'b000:  load_data = {{(XLEN-8){byte_val[7]}}, byte_val};
        3'b001:  load_data = {{(XLEN-16){half_val[15]}}, half_val};
        3'b010:  load_data = old_word;
        3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_val};
        3'b101:  load_data = {{(XLEN-16){1'b0}}, half_val};
        default: bad_funct3 = 1'b1;
      endcase
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    if (!bad_funct3) begin
      misalign = ((eff_funct3[1:0] == 2'b01) && lane[0]) ||
                 ((eff_funct3[1:0] == 2'b10) && (lane != 2'b00));
    end
`endif
  end

  assign err_c   = bad_funct3 || misalign;
  assign rdata_c = (eff_we || err_c) ? '0 : load_data;

  always_comb begin
    merged = old_word;
    for (int b = 0; b < XLEN/8; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = store_pat[b*8 +: 8];
    end
  end

  // Storage is deliberately outside the reset domain so a reset never clears its contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= merged;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            if (LATENCY == 1) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rdata_c;
              rsp_err_o   <= err_c;
            end else begin
              state <= WAIT;
              cnt   <= 3'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rdata_c;
            rsp_err_o   <= err_c;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY=3, MEM_WORDS=2048.
// Expectations follow DMEM_MISALIGN_CHECK_EN when the macro is defined for the build.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .MEM_WORDS(2048), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response exchange; lat counts cycles from the accept edge to rsp_valid.
  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_timeout", 32'(guard >= 20), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    apply_stimulus(we, f3, addr, wdata, rd, er, lat);
    check_output({tag, "_lat"}, 32'(lat), 32'd3);
    check_output({tag, "_rdata"}, rd, exp_rdata);
    check_output({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    int guard;
    int saw_valid;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rdata", rsp_rdata, 32'd0);
    check_output("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1 check_output("ready_after_rst", 32'(req_ready), 32'd1);

    // Word store/load and latency
    txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Sub-word stores and extended loads
    txn("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    txn("sb_21", 1'b1, 3'b000, 32'h21, 32'h000000A5, 32'h0, 1'b0);
    txn("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122A544, 1'b0);
    txn("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFA5, 1'b0);
    txn("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000A5, 1'b0);
    txn("lh_20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFA544, 1'b0);
    txn("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00001122, 1'b0);
    txn("sh_22", 1'b1, 3'b001, 32'h22, 32'hFFFF8001, 32'h0, 1'b0);
    txn("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'h8001A544, 1'b0);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_CHECK_EN
    txn("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
    txn("sh_23_mis", 1'b1, 3'b001, 32'h23, 32'h0000BBBB, 32'h0, 1'b1);
    txn("lw_20_after_sh23", 1'b0, 3'b010, 32'h20, 32'h0, 32'h8001A544, 1'b0);
`else
    txn("lw_22_nochk", 1'b0, 3'b010, 32'h22, 32'h0, 32'h8001A544, 1'b0);
    txn("sh_23_nochk", 1'b1, 3'b001, 32'h23, 32'h0000BBBB, 32'h0, 1'b0);
    txn("lw_20_after_sh23", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBBBBA544, 1'b0);
`endif

    // Backpressure: response held, a competing store must not be taken
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 20);
    check_output("bp_lat", 32'(guard), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check_output("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check_output("bp_ready_after", 32'(req_ready), 32'd1);
    check_output("bp_valid_after", 32'(rsp_valid), 32'd0);
    txn("lw_10_after_bp", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Unsupported funct3 and address aliasing
    txn("st_f3_111", 1'b1, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("lw_alias_2010", 1'b0, 3'b010, 32'h2010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset while a store is waiting
    txn("sw_30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_valid", 32'(rsp_valid), 32'd0);
    check_output("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid++;
    end
    check_output("midrst_no_rsp", 32'(saw_valid), 32'd0);
    txn("lw_30_after_rst", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
